ifu_fetch_ysyx_24100029: RTL
============================

IFU_FETCH_YSYX_24100029 -- requirements
Module: ifu_fetch_ysyx_24100029

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h80000000, first fetch address after reset.
REQ-002 SHALL have parameter TIMEOUT, default 255, maximum cycles spent waiting for an instruction-memory response.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 req_valid  output  1  fetch request to instruction memory.
REQ-006 req_addr  output  32  fetch address, word-aligned.
REQ-007 req_ready  input  1  memory accepts request when high with req_valid.
REQ-008 resp_valid  input  1  memory returns instruction word.
REQ-009 resp_data  input  32  instruction word.
REQ-010 resp_err  input  1  access fault, qualified by resp_valid.
REQ-011 inst_valid  output  1  instruction presented to core.
REQ-012 inst  output  32  instruction word to core.
REQ-013 inst_pc  output  32  address of inst.
REQ-014 inst_fault  output  2  00 none, 01 access error, 10 timeout, 11 misaligned.
REQ-015 inst_ready  input  1  core accepts instruction when high with inst_valid.
REQ-016 npc_valid  input  1  core supplies next pc (one-cycle pulse after retiring).
REQ-017 npc  input  32  next fetch address.
REQ-018 fetch_cnt  output  32  count of instructions accepted by core.

Function
REQ-019 SHALL implement FSM S_IDLE, S_REQ, S_WAIT, S_OUT, S_NPC; all outputs registered or decoded from registered state only.
REQ-020 S_IDLE -> S_REQ unconditionally on the first clock edge after reset release.
REQ-021 S_REQ: req_valid=1, req_addr=pc; on req_valid&&req_ready -> S_WAIT, timeout counter cleared; req_addr stable until accepted.
REQ-022 S_WAIT: on resp_valid latch inst=resp_data, inst_pc=pc, inst_fault=resp_err?01:00 -> S_OUT; responses are required no earlier than one cycle after request acceptance.
REQ-023 S_WAIT: 8-bit counter increments each cycle without resp_valid; when it reaches TIMEOUT -> S_OUT with inst=32'h0, inst_fault=10.
REQ-024 resp_valid outside S_WAIT SHALL be discarded with no state change.
REQ-025 S_OUT: inst_valid=1, inst/inst_pc/inst_fault held stable; on inst_valid&&inst_ready -> S_NPC, fetch_cnt increments by 1 (wraps 32'hFFFFFFFF -> 0).
REQ-026 S_NPC: inst_valid=0; on npc_valid latch pc=npc; if npc[1:0]==0 -> S_REQ, else -> S_OUT with inst=32'h0, inst_pc=npc, inst_fault=11, no memory request issued.
REQ-027 npc_valid outside S_NPC SHALL be ignored.
REQ-028 Latency: req acceptance to inst_valid = response latency + 1 cycle; npc_valid to req_valid = 1 cycle.
REQ-029 At most one request outstanding at any time.

Reset
REQ-030 On rst_n low, immediately: state=S_IDLE, pc=RESET_PC, req_valid=0, req_addr=RESET_PC, inst_valid=0, inst=0, inst_pc=0, inst_fault=00, fetch_cnt=0, timeout counter=0.
REQ-031 Reset asserted mid-operation (any state) SHALL abandon the outstanding request; a response arriving after reset is discarded per REQ-024.

Verification
REQ-032 Reset release, req_ready=1, response data 32'h00000413 after 2 cycles -> req_addr=32'h80000000, inst_valid with inst=32'h00000413, inst_pc=32'h80000000, fault 00.
REQ-033 req_ready low 5 cycles -> req_valid held, req_addr constant; inst_ready low 3 cycles -> inst stable, fetch_cnt increments once.
REQ-034 No response, TIMEOUT=4 -> inst_valid after 4 wait cycles, inst=0, inst_fault=10; later stray resp_valid ignored.
REQ-035 resp_err=1 -> inst_fault=01; npc=32'h80000006 -> no req_valid, inst_pc=32'h80000006, inst_fault=11.
REQ-036 rst_n low during S_WAIT, response arrives after release -> outputs at reset values, fresh request to 32'h80000000, stale response not presented.

Source files
------------

// File: rtl/ifu_fetch_ysyx_24100029.sv
// Instruction fetch unit: issues one word fetch at a time to instruction
// memory, presents the returned word (or a fault) to the core, then waits for
// the core to supply the next fetch address.
//
// Fault encoding on inst_fault:
//   00 no fault, 01 memory access error, 10 response timeout, 11 misaligned pc
//
// The request and instruction handshakes are decoded straight from the state
// register. Every other output is a dedicated register, so nothing the core or
// the memory sees depends combinationally on an input.
module ifu_fetch_ysyx_24100029 #(
    parameter logic [31:0] RESET_PC = 32'h80000000,
    parameter int unsigned TIMEOUT  = 255
) (
    input  logic        clk,
    input  logic        rst_n,

    // instruction memory request channel
    output logic        req_valid,
    output logic [31:0] req_addr,
    input  logic        req_ready,

    // instruction memory response channel
    input  logic        resp_valid,
    input  logic [31:0] resp_data,
    input  logic        resp_err,

    // instruction channel towards the core
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic [1:0]  inst_fault,
    input  logic        inst_ready,

    // next-pc feedback from the core
    input  logic        npc_valid,
    input  logic [31:0] npc,

    output logic [31:0] fetch_cnt
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_WAIT = 3'd2,
        S_OUT  = 3'd3,
        S_NPC  = 3'd4
    } state_t;

    localparam logic [1:0] FAULT_NONE     = 2'b00;
    localparam logic [1:0] FAULT_ACCESS   = 2'b01;
    localparam logic [1:0] FAULT_TIMEOUT  = 2'b10;
    localparam logic [1:0] FAULT_MISALIGN = 2'b11;

    // The wait counter is 8 bits wide, so only the low byte of TIMEOUT matters.
    localparam logic [7:0] TIMEOUT_LIM = 8'(TIMEOUT);

    state_t      state_reg,      state_next;
    logic [31:0] pc_reg,         pc_next;
    logic [31:0] req_addr_reg,   req_addr_next;
    logic [31:0] inst_reg,       inst_next;
    logic [31:0] inst_pc_reg,    inst_pc_next;
    logic [1:0]  inst_fault_reg, inst_fault_next;
    logic [31:0] fetch_cnt_reg,  fetch_cnt_next;
    logic [7:0]  tmo_cnt_reg,    tmo_cnt_next;
    logic [7:0]  tmo_cnt_inc;

    assign tmo_cnt_inc = tmo_cnt_reg + 8'd1;

    // FSM state register; reset drops straight back to idle, which abandons
    // any request still in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Datapath registers: fetch pc, request address, presented instruction,
    // retired-instruction counter and response timeout counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_reg         <= RESET_PC;
            req_addr_reg   <= RESET_PC;
            inst_reg       <= 32'h0;
            inst_pc_reg    <= 32'h0;
            inst_fault_reg <= FAULT_NONE;
            fetch_cnt_reg  <= 32'h0;
            tmo_cnt_reg    <= 8'h0;
        end else begin
            pc_reg         <= pc_next;
            req_addr_reg   <= req_addr_next;
            inst_reg       <= inst_next;
            inst_pc_reg    <= inst_pc_next;
            inst_fault_reg <= inst_fault_next;
            fetch_cnt_reg  <= fetch_cnt_next;
            tmo_cnt_reg    <= tmo_cnt_next;
        end
    end

    // Next-state and next-datapath decode; every register holds by default,
    // so inputs arriving in a state that does not expect them have no effect.
    always_comb begin
        state_next      = state_reg;
        pc_next         = pc_reg;
        req_addr_next   = req_addr_reg;
        inst_next       = inst_reg;
        inst_pc_next    = inst_pc_reg;
        inst_fault_next = inst_fault_reg;
        fetch_cnt_next  = fetch_cnt_reg;
        tmo_cnt_next    = tmo_cnt_reg;

        case (state_reg)
            S_IDLE: begin
                state_next = S_REQ;
            end

            S_REQ: begin
                // req_valid is high throughout this state, so req_ready alone
                // completes the handshake.
                if (req_ready) begin
                    state_next   = S_WAIT;
                    tmo_cnt_next = 8'h0;
                end
            end

            S_WAIT: begin
                // A response arriving on the timeout cycle still wins: the
                // counter only advances on cycles without resp_valid.
                if (resp_valid) begin
                    inst_next       = resp_data;
                    inst_pc_next    = pc_reg;
                    inst_fault_next = resp_err ? FAULT_ACCESS : FAULT_NONE;
                    state_next      = S_OUT;
                end else begin
                    tmo_cnt_next = tmo_cnt_inc;
                    if (tmo_cnt_inc == TIMEOUT_LIM) begin
                        inst_next       = 32'h0;
                        inst_pc_next    = pc_reg;
                        inst_fault_next = FAULT_TIMEOUT;
                        state_next      = S_OUT;
                    end
                end
            end

            S_OUT: begin
                if (inst_ready) begin
                    fetch_cnt_next = fetch_cnt_reg + 32'd1;
                    state_next     = S_NPC;
                end
            end

            S_NPC: begin
                if (npc_valid) begin
                    pc_next = npc;
                    if (npc[1:0] == 2'b00) begin
                        // Only aligned addresses ever reach req_addr.
                        req_addr_next = npc;
                        state_next    = S_REQ;
                    end else begin
                        // Misaligned target: report it directly without
                        // touching memory.
                        inst_next       = 32'h0;
                        inst_pc_next    = npc;
                        inst_fault_next = FAULT_MISALIGN;
                        state_next      = S_OUT;
                    end
                end
            end

            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    assign req_valid  = (state_reg == S_REQ);
    assign req_addr   = req_addr_reg;
    assign inst_valid = (state_reg == S_OUT);
    assign inst       = inst_reg;
    assign inst_pc    = inst_pc_reg;
    assign inst_fault = inst_fault_reg;
    assign fetch_cnt  = fetch_cnt_reg;

endmodule
